// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs,
// ALU encoding, FSM states and the control bundle driven into the datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [1:0] {
        SRCB_B, SRCB_4, SRCB_IMM, SRCB_BRANCH
    } srcb_e;

    typedef enum logic [1:0] {
        PC_ALU, PC_ALUOUT, PC_JUMP
    } pc_src_e;

    typedef struct packed {
        logic    pc_we;
        pc_src_e pc_src;
        logic    ir_we;
        logic    mdr_we;
        logic    ab_we;
        logic    out_we;
        logic    srca_pc;
        srcb_e   srcb;
        alu_op_e alu_op;
        logic    rf_we;
        logic    rf_dst_rd;
        logic    rf_from_mdr;
        logic    addr_from_out;
        logic    mem_req;
        logic    mem_we;
        logic    halted;
    } ctl_t;

    function automatic logic funct_legal(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
        alu_op_e op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_multi_ctl.sv
// Control FSM for the multi-cycle MIPS core: sequences each instruction
// and drives datapath enables, mux selects and the ALU operation.
module mips_multi_ctl
    import mips_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic [1:0] alu_lo_i,
    input  logic       mem_ready_i,
    output ctl_t       ctl_o
);

    state_e state_q, state_d, ill_state;
    ctl_t   c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        c         = '0;
        ill_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        case (state_q)
            S_FETCH: begin
                c.mem_req = rst_n;
                c.srca_pc = 1'b1;
                c.srcb    = SRCB_4;
                if (mem_ready_i) begin
                    c.ir_we  = 1'b1;
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_ALU;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                c.ab_we   = 1'b1;
                c.out_we  = 1'b1;
                c.srca_pc = 1'b1;
                c.srcb    = SRCB_BRANCH;
                unique case (1'b1)
                    (op_i == OP_RTYPE && funct_legal(funct_i)),
                    (op_i == OP_ADDI):                  state_d = S_EXEC;
                    (op_i == OP_LW || op_i == OP_SW):   state_d = S_ADDR;
                    (op_i == OP_BEQ || op_i == OP_BNE): state_d = S_BRANCH;
                    (op_i == OP_J):                     state_d = S_JUMP;
                    default:                            state_d = ill_state;
                endcase
            end
            S_EXEC: begin
                c.out_we = 1'b1;
                c.srcb   = (op_i == OP_RTYPE) ? SRCB_B : SRCB_IMM;
                c.alu_op = (op_i == OP_RTYPE) ? funct_to_alu(funct_i)
                                              : ALU_ADD;
                state_d  = S_WB_ALU;
            end
            S_WB_ALU: begin
                c.rf_we     = 1'b1;
                c.rf_dst_rd = (op_i == OP_RTYPE);
                state_d     = S_FETCH;
            end
            S_ADDR: begin
                c.out_we = 1'b1;
                c.srcb   = SRCB_IMM;
                if (alu_lo_i != 2'b00) state_d = ill_state;
                else if (op_i == OP_LW) state_d = S_MEM_RD;
                else state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                c.mem_req       = 1'b1;
                c.addr_from_out = 1'b1;
                if (mem_ready_i) begin
                    c.mdr_we = 1'b1;
                    state_d  = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                c.rf_we       = 1'b1;
                c.rf_from_mdr = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                c.mem_req       = 1'b1;
                c.mem_we        = 1'b1;
                c.addr_from_out = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_BRANCH: begin
                c.srcb   = SRCB_B;
                c.alu_op = ALU_SUB;
                if ((op_i == OP_BEQ) == zero_i) begin
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_ALUOUT;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                c.pc_we  = 1'b1;
                c.pc_src = PC_JUMP;
                state_d  = S_FETCH;
            end
            S_HALT:  c.halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    assign ctl_o = c;

endmodule

// File: rtl/mips_multi.sv
// Multi-cycle MIPS core datapath: PC/IR/MDR/A/B/ALUOut, register file
// and shared ALU behind a single wait-state memory port.
module mips_multi
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [31:0] pc_out
);

    logic [1:0]  sync_q;
    logic        rst_n;
    ctl_t        ctl;
    logic [31:0] pc_q, pc_d, ir_q, mdr_q, a_q, b_q, out_q;
    logic [31:0] rf_q [32];
    logic [31:0] imm, alu_a, alu_b, alu_y, rf_wd;
    logic [4:0]  rf_wa;

    // Assertion is immediate; release is held off two edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_n = sync_q[1];

    mips_multi_ctl #(
        .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
    ) u_ctl (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_i       (ir_q[31:26]),
        .funct_i    (ir_q[5:0]),
        .zero_i     (alu_y == 32'd0),
        .alu_lo_i   (alu_y[1:0]),
        .mem_ready_i(mem_ready),
        .ctl_o      (ctl)
    );

    assign imm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign alu_a = ctl.srca_pc ? pc_q : a_q;

    always_comb begin
        case (ctl.srcb)
            SRCB_B:   alu_b = b_q;
            SRCB_4:   alu_b = 32'd4;
            SRCB_IMM: alu_b = imm;
            default:  alu_b = {imm[29:0], 2'b00};
        endcase
    end

    always_comb begin
        case (ctl.alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        case (ctl.pc_src)
            PC_ALU:    pc_d = alu_y;
            PC_ALUOUT: pc_d = out_q;
            PC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            mdr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            if (ctl.pc_we)  pc_q  <= pc_d;
            if (ctl.ir_we)  ir_q  <= mem_rdata;
            if (ctl.mdr_we) mdr_q <= mem_rdata;
            if (ctl.out_we) out_q <= alu_y;
            if (ctl.ab_we) begin
                a_q <= rf_q[ir_q[25:21]];
                b_q <= rf_q[ir_q[20:16]];
            end
        end
    end

    assign rf_wa = ctl.rf_dst_rd ? ir_q[15:11] : ir_q[20:16];
    assign rf_wd = ctl.rf_from_mdr ? mdr_q : out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (ctl.rf_we && rf_wa != 5'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    assign mem_req   = ctl.mem_req;
    assign mem_we    = ctl.mem_we;
    assign mem_addr  = ctl.addr_from_out ? out_q : pc_q;
    assign mem_wdata = b_q;
    assign halted    = ctl.halted;
    assign pc_out    = pc_q;

endmodule

// File: doc/mips_multi.md
# mips_multi

Multi-cycle MIPS core, the successor to the single-cycle datapath. Executes the same subset (R-type add/sub/and/or/slt, addi, lw, sw, beq, bne, j) through a control FSM over a shared ALU and one unified memory port with a ready/valid-style wait handshake. Memory is external, so the core tolerates variable-latency instruction and data memory. Reset vector and illegal-instruction handling are configurable.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- HALT_ON_ILLEGAL, 1: 1 means an unknown opcode/funct or a misaligned lw/sw address enters HALT; 0 means it is executed as a no-op.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write (sw), 0 = read (fetch/lw); valid while mem_req=1.
- mem_addr  out  32  byte address, word-aligned.
- mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  32  read data; sampled on the edge where mem_req=1 and mem_ready=1.
- mem_ready  in  1  transfer completes on the edge where mem_req=1 and mem_ready=1; may be combinational from mem_req.
- halted  out  1  core is in HALT.
- pc_out  out  32  current PC register, for debug and the bench.

## Operation
- Internal state: PC, IR, MDR, A, B, ALUOut, 32x32 register file. $0 always reads 0; writes to $0 are dropped.
- FETCH: mem_req=1, we=0, addr=PC. On completion: IR<=rdata, PC<=PC+4, go to DECODE. While mem_ready=0, stay in FETCH with all outputs stable.
- DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode:
  - R-type or addi goes to EXEC.
  - lw or sw goes to ADDR.
  - beq or bne goes to BRANCH.
  - j goes to JUMP.
  - Anything else goes to HALT, or to FETCH when HALT_ON_ILLEGAL=0.
- EXEC: ALUOut<=A op (B or sext(imm)). Go to WB_ALU.
- WB_ALU: rf[rd for R-type, rt for addi]<=ALUOut. Go to FETCH.
- ADDR: ALUOut<=A+sext(imm). If the result has bits [1:0]!=0, apply the illegal rule. Otherwise go to MEM_RD for lw or MEM_WR for sw.
- MEM_RD: read request at ALUOut. On completion MDR<=rdata, go to WB_MEM.
- WB_MEM: rf[rt]<=MDR. Go to FETCH.
- MEM_WR: write request, addr=ALUOut, wdata=B. On completion go to FETCH.
- BRANCH: compute A-B. For beq with zero=1, or bne with zero=0, PC<=ALUOut. Go to FETCH.
- JUMP: PC<={PC[31:28], IR[25:0], 2'b00}. Go to FETCH.
- HALT: terminal state. mem_req=0, halted=1. Left only by reset.
- Funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct is illegal.
- Arithmetic: 32-bit wrap, no overflow trap. slt is signed.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IR/MDR/A/B/ALUOut/all registers=0, halted=0.
- mem_req is 0 while reset is low. It goes to 1 combinationally in FETCH after reset release.
- Deassertion of reset is synchronised internally with a 2-flop synchroniser. The first FETCH request appears 2 edges after reset rises.
- Cycle counts with zero wait states (mem_ready tied to 1):
  - R-type and addi: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne and j: 3.
  - Each cycle of mem_ready=0 during a request adds exactly one cycle.
- While mem_req=1, mem_addr, mem_we and mem_wdata do not change until completion.
- mem_req drops in the cycle after completion unless the next state also requests (for example MEM_WR to FETCH). Back-to-back requests are legal.
- Reset asserted mid-transfer drops mem_req immediately. No register-file write occurs for the interrupted instruction.
- Outputs are registered state or decode of the state register only. There is no combinational path from mem_rdata to any output.

## Structure
- Package mips_pkg holds:
  - the opcode constants (R=0x00, j=0x02, beq=0x04, bne=0x05, addi=0x08, lw=0x23, sw=0x2B);
  - the funct constants;
  - the ALU operation encoding;
  - the state enum.
- One sub-module, mips_multi_ctl: the FSM plus decode, driving datapath enables, mux selects and the ALU op.
- The datapath, register file and ALU stay in mips_multi.

## Test plan
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2, zero-wait memory: $3=12, 12 cycles total, pc_out=0x0C.
- sw $3,0x40($0) then lw $4,0x40($0), with mem_ready low for 2 cycles on every access: mem holds 12 at 0x40, $4=12, lw takes 5+4=9 cycles.
- beq $1,$1,+2 at 0x10: pc_out becomes 0x1C. bne $1,$1,+2: pc_out becomes 0x14. Each takes 3 cycles.
- j 0x100 at PC 0x20: pc_out=0x400. addi $0,$0,9 followed by a read of $0: the read returns 0.
- Opcode 0x3F with HALT_ON_ILLEGAL=1: halted=1 three cycles after fetch, mem_req stays 0, PC is frozen. With HALT_ON_ILLEGAL=0 the core continues at PC+4. lw at address 0x41 also halts.
- Reset pulled low while a FETCH is stalled with mem_ready=0: mem_req=0 in the same cycle. After release, the first request goes to RESET_PC=0x0000_1000, 2 edges later.
